// File: rtl/fir_dout_requant.sv
// -----------------------------------------------------------------------------
// fir_dout_requant
//
// Receive-side requantizer for the FIR output stream. Each accepted 18-bit
// signed filter result is rounded (round-half-up), arithmetically shifted
// right by SHIFT, and saturated to OUT_W signed bits. The result is queued in
// a small FIFO and presented to a downstream consumer over valid/ready.
// The FIR side has no backpressure; a sample arriving at a full FIFO (with
// no pop in the same cycle) is dropped and flagged.
//
// Optional feature macro: REQUANT_STATS_EN
//   defined   : sat_count / drop_count are saturating 16-bit event counters
//   undefined : counter logic is removed and both ports are tied to zero
//
// Ports:
//   clk           rising-edge clock, single domain
//   reset         asynchronous active-low reset (0 = in reset)
//   din_valid     din carries a new FIR sample this cycle
//   din           signed FIR output sample, IN_W bits
//   dout_valid    FIFO non-empty; dout holds the head entry
//   dout_ready    consumer accepts dout when dout_valid=1
//   dout          signed requantized sample at FIFO head, OUT_W bits
//   full          FIFO holds DEPTH entries
//   sat_flag      one-cycle pulse: the sample just written was clipped
//   overflow_drop one-cycle pulse: a sample was discarded (FIFO full)
//   sat_count     saturating count of clipped samples written
//   drop_count    saturating count of dropped samples
// -----------------------------------------------------------------------------
module fir_dout_requant #(
    parameter int IN_W  = 18,
    parameter int OUT_W = 8,
    parameter int SHIFT = 10,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    din_valid,
    input  logic signed [IN_W-1:0]  din,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic signed [OUT_W-1:0] dout,
    output logic                    full,
    output logic                    sat_flag,
    output logic                    overflow_drop,
    output logic [15:0]             sat_count,
    output logic [15:0]             drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Rounding constant 2^(SHIFT-1) and clip limits, all in IN_W+1 bits so the
    // rounding add can never wrap and comparisons stay signed.
    localparam logic signed [IN_W:0] HALF    = $signed((IN_W+1)'(1) << (SHIFT-1));
    localparam logic signed [IN_W:0] SAT_MAX = $signed({{(IN_W-OUT_W+2){1'b0}},
                                                        {(OUT_W-1){1'b1}}});
    localparam logic signed [IN_W:0] SAT_MIN = ~SAT_MAX;

    // Round half toward +inf, then arithmetic shift right.
    function automatic logic signed [IN_W:0] round_shift(input logic signed [IN_W-1:0] x);
        logic signed [IN_W:0] ext;
        logic signed [IN_W:0] sum;
        ext = $signed({x[IN_W-1], x});
        sum = ext + HALF;
        return sum >>> SHIFT;
    endfunction

    // Returns {clip, value}: value clamped to the OUT_W signed range.
    function automatic logic [OUT_W:0] saturate(input logic signed [IN_W:0] r);
        logic [OUT_W:0] o;
        if (r > SAT_MAX) begin
            o = {1'b1, SAT_MAX[OUT_W-1:0]};
        end else if (r < SAT_MIN) begin
            o = {1'b1, SAT_MIN[OUT_W-1:0]};
        end else begin
            o = {1'b0, r[OUT_W-1:0]};
        end
        return o;
    endfunction

    // Stage 1: round / shift / saturate
    logic signed [IN_W:0]    rnd;
    logic [OUT_W:0]          sat;
    logic signed [OUT_W-1:0] res_p1_d, res_p1_q;
    logic                    clip_p1_d, clip_p1_q;
    logic                    vld_p1_d, vld_p1_q;

    always_comb begin
        rnd       = round_shift(din);
        sat       = saturate(rnd);
        vld_p1_d  = din_valid;
        res_p1_d  = res_p1_q;
        clip_p1_d = clip_p1_q;
        if (din_valid) begin
            res_p1_d  = sat[OUT_W-1:0];
            clip_p1_d = sat[OUT_W];
        end
    end

    always_ff @(posedge clk) begin
        res_p1_q  <= res_p1_d;
        clip_p1_q <= clip_p1_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
        end
    end

    // Stage 2: FIFO write, pop, status pulses
    logic signed [OUT_W-1:0] mem [DEPTH];
    logic [PW-1:0]           wr_ptr_d, wr_ptr_q;
    logic [PW-1:0]           rd_ptr_d, rd_ptr_q;
    logic                    empty;
    logic                    full_int;
    logic                    pop;
    logic                    push_ok;
    logic                    drop;
    logic                    sat_flag_d, sat_flag_q;
    logic                    overflow_drop_d, overflow_drop_q;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full_int = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop      = !empty && dout_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_ok  = vld_p1_q && (!full_int || pop);
        drop     = vld_p1_q && !push_ok;

        wr_ptr_d        = wr_ptr_q + PW'(push_ok);
        rd_ptr_d        = rd_ptr_q + PW'(pop);
        sat_flag_d      = push_ok && clip_p1_q;
        overflow_drop_d = drop;
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q[AW-1:0]] <= res_p1_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            sat_flag_q      <= 1'b0;
            overflow_drop_q <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            sat_flag_q      <= sat_flag_d;
            overflow_drop_q <= overflow_drop_d;
        end
    end

    // Storage is not reset, so dout is forced to zero whenever nothing is queued.
    always_comb begin
        dout_valid    = !empty;
        dout          = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
        full          = full_int;
        sat_flag      = sat_flag_q;
        overflow_drop = overflow_drop_q;
    end

`ifdef REQUANT_STATS_EN
    logic [15:0] sat_cnt_d, sat_cnt_q;
    logic [15:0] drop_cnt_d, drop_cnt_q;

    // Counters stick at all-ones instead of wrapping.
    always_comb begin
        sat_cnt_d  = sat_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (sat_flag_d && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            sat_cnt_q  <= sat_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign sat_count  = sat_cnt_q;
    assign drop_count = drop_cnt_q;
`else
    assign sat_count  = 16'h0;
    assign drop_count = 16'h0;
`endif

endmodule

// File: tb/tb_fir_dout_requant.sv
module tb_fir_dout_requant;

    logic               clk = 1'b0;
    logic               reset;
    logic               din_valid;
    logic signed [17:0] din;
    logic               dout_valid;
    logic               dout_ready;
    logic [7:0]         dout;
    logic               full;
    logic               sat_flag;
    logic               overflow_drop;
    logic [15:0]        sat_count;
    logic [15:0]        drop_count;

`ifdef REQUANT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int exp_sat = 0;
    int exp_drop = 0;

    always #5 clk = ~clk;

    fir_dout_requant #(
        .IN_W (18),
        .OUT_W(8),
        .SHIFT(10),
        .DEPTH(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .din_valid    (din_valid),
        .din          (din),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .dout         (dout),
        .full         (full),
        .sat_flag     (sat_flag),
        .overflow_drop(overflow_drop),
        .sat_count    (sat_count),
        .drop_count   (drop_count)
    );

    typedef struct {
        int         din;
        logic [7:0] dout;
        logic       sat;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [15:0] cnt(input int v);
        return STATS ? 16'(v) : 16'h0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1024,    8'h01, 1'b0};
        vecs[1] = '{512,     8'h01, 1'b0};
        vecs[2] = '{511,     8'h00, 1'b0};
        vecs[3] = '{-512,    8'h00, 1'b0};
        vecs[4] = '{-513,    8'hFF, 1'b0};
        vecs[5] = '{131071,  8'h7F, 1'b1};
        vecs[6] = '{-131072, 8'h80, 1'b0};

        reset      = 1'b0;
        din_valid  = 1'b0;
        din        = '0;
        dout_ready = 1'b0;
        tick;
        tick;
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_sat_flag", 32'(sat_flag), 32'd0);
        chk("rst_overflow_drop", 32'(overflow_drop), 32'd0);
        chk("rst_sat_count", 32'(sat_count), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);
        reset = 1'b1;
        tick;

        // Single pulses through the rounding/saturation table
        dout_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            din       = 18'(vecs[i].din);
            din_valid = 1'b1;
            tick;
            din_valid = 1'b0;
            chk("vec_not_early", 32'(dout_valid), 32'd0);
            tick;
            chk("vec_valid", 32'(dout_valid), 32'd1);
            chk("vec_dout", 32'(dout), 32'(vecs[i].dout));
            chk("vec_sat_flag", 32'(sat_flag), 32'(vecs[i].sat));
            if (vecs[i].sat) exp_sat++;
            chk("vec_sat_count", 32'(sat_count), 32'(cnt(exp_sat)));
            tick;
            chk("vec_popped", 32'(dout_valid), 32'd0);
            chk("vec_sat_flag_clr", 32'(sat_flag), 32'd0);
        end

        // Overflow: 5 samples into a stalled 4-entry FIFO
        dout_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            din       = 18'(1024 * k);
            din_valid = 1'b1;
            tick;
            chk("ovf_full", 32'(full), 32'(k == 5));
            chk("ovf_no_drop_yet", 32'(overflow_drop), 32'd0);
        end
        din_valid = 1'b0;
        chk("ovf_head", 32'(dout), 32'd1);
        tick;
        exp_drop++;
        chk("ovf_drop_pulse", 32'(overflow_drop), 32'd1);
        chk("ovf_drop_count", 32'(drop_count), 32'(cnt(exp_drop)));
        chk("ovf_full_hold", 32'(full), 32'd1);
        chk("ovf_head_stable", 32'(dout), 32'd1);
        chk("ovf_sat_count", 32'(sat_count), 32'(cnt(exp_sat)));
        tick;
        chk("ovf_drop_clr", 32'(overflow_drop), 32'd0);
        dout_ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            chk("drain_valid", 32'(dout_valid), 32'd1);
            chk("drain_dout", 32'(dout), 32'(j));
            chk("drain_full", 32'(full), 32'(j == 1));
            tick;
        end
        chk("drain_empty", 32'(dout_valid), 32'd0);

        // Full FIFO with a continuous stream and the consumer ready
        dout_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            din       = 18'(1024 * k);
            din_valid = 1'b1;
            tick;
        end
        chk("stream_full_start", 32'(full), 32'd1);
        dout_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            din = 18'(1024 * (6 + j));
            tick;
            chk("stream_full", 32'(full), 32'd1);
            chk("stream_valid", 32'(dout_valid), 32'd1);
            chk("stream_dout", 32'(dout), 32'(2 + j));
            chk("stream_no_drop", 32'(overflow_drop), 32'd0);
        end
        din_valid = 1'b0;
        repeat (6) tick;
        chk("stream_drained", 32'(dout_valid), 32'd0);
        chk("stream_drop_count", 32'(drop_count), 32'(cnt(exp_drop)));

        // Asynchronous reset with entries queued and a sample in flight
        dout_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            din       = 18'(1024 * k);
            din_valid = 1'b1;
            tick;
        end
        din_valid = 1'b0;
        chk("prerst_valid", 32'(dout_valid), 32'd1);
        chk("prerst_dout", 32'(dout), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(dout_valid), 32'd0);
        chk("arst_full", 32'(full), 32'd0);
        chk("arst_dout", 32'(dout), 32'd0);
        chk("arst_sat_count", 32'(sat_count), 32'd0);
        chk("arst_drop_count", 32'(drop_count), 32'd0);
        exp_sat  = 0;
        exp_drop = 0;
        tick;
        #2;
        reset = 1'b1;
        tick;
        chk("postrst_lost", 32'(dout_valid), 32'd0);
        dout_ready = 1'b1;
        din        = 18'(2048);
        din_valid  = 1'b1;
        tick;
        din_valid = 1'b0;
        chk("postrst_not_early", 32'(dout_valid), 32'd0);
        tick;
        chk("postrst_valid", 32'(dout_valid), 32'd1);
        chk("postrst_dout", 32'(dout), 32'd2);
        tick;
        chk("postrst_popped", 32'(dout_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_dout_requant.md
Name: fir_dout_requant

Overview:
Receive-side block for the FIR output stream. It takes the 18-bit signed filter result one sample per cycle and requantizes it back to 8-bit signed by rounding and saturating. Results are buffered in a small FIFO and handed to a downstream consumer over a valid/ready handshake. It sits directly on the FIR Dout bus and returns data to the same 8-bit format the FIR consumes on Din.

Parameters:
IN_W, 18, input sample width (signed two's complement)
OUT_W, 8, output sample width (signed two's complement)
SHIFT, 10, right-shift applied after rounding; must satisfy 1 <= SHIFT < IN_W
DEPTH, 4, output FIFO entries; power of two, minimum 2

Ports:
clk  in  1  rising-edge clock, sole clock domain
reset  in  1  asynchronous active-low reset; 0 = in reset
din_valid  in  1  din carries a new FIR sample this cycle; no backpressure toward FIR
din  in  IN_W  signed FIR output sample
dout_valid  out  1  FIFO non-empty; dout holds the head entry
dout_ready  in  1  consumer accepts dout when dout_valid=1
dout  out  OUT_W  signed requantized sample at FIFO head
full  out  1  FIFO holds DEPTH entries
sat_flag  out  1  one-cycle pulse: the sample entering the FIFO this cycle was clipped
overflow_drop  out  1  one-cycle pulse: a sample was discarded because the FIFO was full
sat_count  out  16  saturating count of clipped samples
drop_count  out  16  saturating count of dropped samples

Behaviour:
- Reset (reset=0, async assert, sync deassert at the flop level): FIFO emptied; dout_valid=0, dout=0, full=0, sat_flag=0, overflow_drop=0, sat_count=0, drop_count=0; the stage-1 valid bit is cleared.
- Stage 1 (edge N, when din_valid=1):
  - compute r = (din + 2^(SHIFT-1)) >>> SHIFT in IN_W+1 bits, so the rounding add never wraps;
  - rounding is round-half-up (toward +inf);
  - saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1];
  - register the result, the clip bit and a valid bit.
- Stage 2 (edge N+1): write the stage-1 result into the FIFO tail if the stage-1 valid bit is set.
  - Fill rule: a push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - Accepted write with the clip bit set: sat_flag=1 for the cycle after the write, and sat_count increments.
  - Rejected write: the sample is discarded; overflow_drop=1 for one cycle; drop_count increments. The sat bookkeeping for a dropped sample is ignored.
- Latency: din_valid sampled at edge N → dout_valid=1 after edge N+1 when the FIFO was empty. Sustained throughput is 1 sample per cycle.
- Pop: occurs at an edge where dout_valid=1 and dout_ready=1; the head advances.
  - dout_ready while empty is ignored.
  - Simultaneous push and pop when empty: the pushed entry becomes the head after that edge; there is no combinational bypass.
- Pointers: log2(DEPTH)+1 bits wrapping naturally. full and empty are derived from the MSB/LSB comparison. Occupancy never exceeds DEPTH.
- dout and dout_valid are driven from registers or FIFO storage only, with no combinational path from din. dout is held stable while dout_valid=1 and dout_ready=0.
- Counters stick at 16'hFFFF and never wrap.
- Mid-operation reset: an in-flight stage-1 sample is lost; the FIFO and counters clear immediately on assertion.

Optional Feature:
REQUANT_STATS_EN
- Defined: sat_count and drop_count operate as specified.
- Undefined: both counters and their logic are removed; the ports remain and are tied to 16'h0. sat_flag, overflow_drop and the datapath are unaffected.

Test Plan:
1. Defaults, dout_ready=1, single pulses of din = 1024, 512, 511, -512, -513 → dout = 1, 1, 0, 0, 8'hFF, each with dout_valid 2 cycles after din_valid and sat_flag=0.
2. din=131071 → dout=127, sat_flag pulse, sat_count=1. din=-131072 → dout=-128 (8'h80), sat_flag=0, since it is in range after rounding.
3. dout_ready=0, push 5 consecutive samples 1024·k for k=1..5 → full=1 after the 4th write; the 5th is dropped with an overflow_drop pulse and drop_count=1. Raising dout_ready then yields 1, 2, 3, 4, followed by dout_valid=0.
4. FIFO full with dout_ready=1 and a continuous din_valid stream → every push pairs with a pop, there are no drops, and full stays 1.
5. Assert reset=0 asynchronously between edges with 3 entries queued → dout_valid, full and counters go to 0 immediately. After release, din=2048 → dout=2 two cycles later.
6. Build without REQUANT_STATS_EN and repeat scenarios 2 and 3 → sat_count=drop_count=0 while the pulses and data still match.
